// File: rtl/pc_gen_if.sv
// pc_gen fetch-side bundle: redirect inputs, stall/handshake, pc outputs.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              en;
    logic              fetch_ready;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;
    logic              br_redirect;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              fetch_valid;
    logic              redirect_taken;
    logic              misalign;

    modport master (
        input  en,
        input  fetch_ready,
        input  exc_req,
        input  eret_req,
        input  epc,
        input  br_redirect,
        input  br_target,
        output pc,
        output pc_plus,
        output fetch_valid,
        output redirect_taken,
        output misalign
    );

    modport slave (
        output en,
        output fetch_ready,
        output exc_req,
        output eret_req,
        output epc,
        output br_redirect,
        output br_target,
        input  pc,
        input  pc_plus,
        input  fetch_valid,
        input  redirect_taken,
        input  misalign
    );
endinterface

// File: rtl/pc_gen.sv
// IF-stage PC generator with prioritised redirects and stall-pending latch.
// Optional target alignment check: define PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h00003000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h00004180),
    parameter int unsigned       INC       = 4
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.master bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC);

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        PEND
    } state_t;

    typedef enum logic [1:0] {
        PRI_NONE,
        PRI_BR,
        PRI_ERET,
        PRI_EXC
    } pri_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_n;
    pri_t              pend_pri_q, pend_pri_n;
    logic              rt_q, rt_n;

    pri_t              req_pri;
    logic [ADDR_W-1:0] req_tgt;
    pri_t              take_pri;
    logic [ADDR_W-1:0] take_tgt;
    logic [ADDR_W-1:0] load_tgt;
    logic              load;
    logic              mis;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= HOLD;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            pend_pri_q <= PRI_NONE;
            rt_q       <= 1'b0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            pend_tgt_q <= pend_tgt_n;
            pend_pri_q <= pend_pri_n;
            rt_q       <= rt_n;
        end
    end

    always_comb begin
        req_pri = PRI_NONE;
        req_tgt = bus.br_target;
        if (bus.exc_req) begin
            req_pri = PRI_EXC;
            req_tgt = EXC_VEC;
        end else if (bus.eret_req) begin
            req_pri = PRI_ERET;
            req_tgt = bus.epc;
        end else if (bus.br_redirect) begin
            req_pri = PRI_BR;
            req_tgt = bus.br_target;
        end
    end

    // Pending slot is empty outside PEND, so a live request always wins there.
    always_comb begin
        take_pri = pend_pri_q;
        take_tgt = pend_tgt_q;
        if (req_pri != PRI_NONE && req_pri >= pend_pri_q) begin
            take_pri = req_pri;
            take_tgt = req_tgt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW = STEP - 1'b1;

    logic mis_q;

    always_comb begin
        load_tgt = take_tgt & ~LOW;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mis_q <= 1'b0;
        end else if (load) begin
            if (take_pri == PRI_EXC) begin
                mis_q <= 1'b0;
            end else if (|(take_tgt & LOW)) begin
                mis_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mis = mis_q;
    end
`else
    always_comb begin
        load_tgt = take_tgt;
        mis      = 1'b0;
    end
`endif

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        pend_tgt_n = pend_tgt_q;
        pend_pri_n = pend_pri_q;
        rt_n       = 1'b0;
        load       = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (take_pri != PRI_NONE) begin
                    state_n    = PEND;
                    pend_tgt_n = take_tgt;
                    pend_pri_n = take_pri;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (take_pri != PRI_NONE) begin
                    if (bus.en) begin
                        load = 1'b1;
                    end else begin
                        state_n    = PEND;
                        pend_tgt_n = take_tgt;
                        pend_pri_n = take_pri;
                    end
                end else if (bus.en && bus.fetch_ready) begin
                    pc_n = pc_q + STEP;
                end
            end
            PEND: begin
                if (bus.en) begin
                    load       = 1'b1;
                    state_n    = RUN;
                    pend_tgt_n = '0;
                    pend_pri_n = PRI_NONE;
                end else begin
                    pend_tgt_n = take_tgt;
                    pend_pri_n = take_pri;
                end
            end
            default: begin
                state_n = HOLD;
            end
        endcase
        if (load) begin
            pc_n = load_tgt;
            rt_n = 1'b1;
        end
    end

    always_comb begin
        bus.fetch_valid    = (state_q == RUN);
        bus.pc             = pc_q;
        bus.pc_plus        = pc_q + STEP;
        bus.redirect_taken = rt_q;
        bus.misalign       = mis;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined MIPS core. It is the next generation of the plain enable/reset PC register.
- Adds:
  - configurable width, reset vector and exception vector
  - prioritised redirect sources (exception, ERET, branch/jump)
  - a pending-redirect latch that holds redirects raised during stalls
  - a valid/ready fetch handshake toward instruction memory
- Sits at the front of the IF stage and drives the instruction-memory address and the IF/ID pc+4 path.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h00003000, PC value loaded on reset.
- EXC_VEC, 32'h00004180, exception handler entry address.
- INC, 4, sequential increment in bytes; must be a power of two.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low (0 = reset); sampled on posedge clk.
- en, input, 1, 1 = PC may advance; 0 = pipeline stall.
- fetch_ready, input, 1, instruction memory accepts the current pc this cycle.
- exc_req, input, 1, exception redirect to EXC_VEC.
- eret_req, input, 1, return redirect to epc.
- epc, input, ADDR_W, ERET target.
- br_redirect, input, 1, branch/jump redirect.
- br_target, input, ADDR_W, branch/jump target.
- pc, output, ADDR_W, current fetch address.
- pc_plus, output, ADDR_W, pc + INC (combinational).
- fetch_valid, output, 1, pc is a valid fetch request.
- redirect_taken, output, 1, one-cycle pulse when pc is loaded from a redirect.
- misalign, output, 1, alignment fault flag; see Optional Feature.

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_VEC, state=HOLD, fetch_valid=0, redirect_taken=0, misalign=0.
  - Any pending redirect is cleared.
  - Reset mid-operation overrides everything.
- States:
  - HOLD: fetch_valid=0. Exactly one cycle after reset is released, then go to RUN. Redirects arriving in HOLD are latched and the state goes to PEND.
  - RUN: fetch_valid=1.
  - PEND: fetch_valid=0. A redirect is held in pend_tgt/pend_pri.
- Redirect priority: exc_req > eret_req > br_redirect. When several are asserted in the same cycle, only the highest is used. Target is EXC_VEC, epc or br_target respectively.
- Advance condition in RUN: adv = en & fetch_ready. On adv with no redirect, pc <= pc + INC, wrapping modulo 2^ADDR_W.
- Hold condition in RUN: en=0 or fetch_ready=0 with no redirect. pc and fetch_valid stay stable; pc must not change while fetch_valid & !fetch_ready, except on redirect.
- Redirect in RUN with en=1:
  - pc <= target next cycle; redirect_taken=1 for that cycle.
  - Any unaccepted request is cancelled. Instruction memory treats an address change under valid as a cancel.
- Redirect in RUN with en=0: latch target and priority, go to PEND.
- PEND:
  - A new redirect of priority >= the held priority replaces the held one. A lower-priority redirect is ignored.
  - On the first cycle with en=1: pc <= held target, redirect_taken=1, state goes to RUN, fetch_valid=1 from that cycle.
  - If that same cycle carries a redirect of priority >= the held priority, it wins.
- redirect_taken is registered, high exactly one cycle per load, and 0 otherwise.
- Latency: a redirect sampled at edge N appears on pc after edge N+1 (one cycle).
- pc_plus is combinational from pc and wraps (e.g. 32'hFFFFFFFC -> 0).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Every redirect target with nonzero low log2(INC) bits has those bits cleared before being loaded into pc.
  - misalign is set sticky on that load.
  - misalign is cleared by reset or by an exc_req redirect load.
- Undefined: targets are loaded unmodified, and misalign is tied to 0.

Test Plan:
- Reset then release, fetch_ready=1, en=1 -> pc=0x3000 with fetch_valid=0 for 1 cycle, then 0x3000, 0x3004, 0x3008 with fetch_valid=1.
- fetch_ready=0 for 3 cycles at pc=0x3008 -> pc holds 0x3008, fetch_valid=1 throughout; after ready=1, pc=0x300C.
- br_redirect=1, br_target=0x3100 together with exc_req=1 -> pc=EXC_VEC 0x4180 next cycle, redirect_taken pulse of 1 cycle.
- en=0; br_redirect to 0x3200, then eret_req with epc=0x3300 next cycle, then en=1 -> fetch_valid=0 while pending, pc=0x3300 on release, redirect_taken=1 once.
- Force pc to 0xFFFFFFFC (via br_target) and advance -> pc=0x00000000, pc_plus=0x4.
- With PC_ALIGN_CHECK_EN, br_target=0x3102 -> pc=0x3100, misalign=1 until exc_req load; without the macro -> pc=0x3102, misalign=0.
